// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one bit per clock.
// Latency: XLEN cycles from accept edge to out_valid; divide-by-zero and signed overflow take 1 cycle.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready; no comb path between sides.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out
);
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]   cnt;
    logic [2:0]      op_q;
    logic            neg_q;
    logic [XLEN-1:0] opnd_q;   // multiplicand magnitude or divisor magnitude
    logic [XLEN-1:0] acc_hi;   // product high half / partial remainder
    logic [XLEN-1:0] acc_lo;   // multiplier shifting out / dividend shifting into quotient

    logic            sgn1, sgn2, neg1, neg2, neg_acc;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] mag1, mag2, special_res;

    // Accept-side decode: operand signedness, magnitudes, result sign and the 1-cycle special cases
    always_comb begin
        sgn1     = (op != 3'b011) && (op != 3'b101) && (op != 3'b111);
        sgn2     = (op == 3'b000) || (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
        neg1     = sgn1 & in1[XLEN-1];
        neg2     = sgn2 & in2[XLEN-1];
        mag1     = neg1 ? -in1 : in1;
        mag2     = neg2 ? -in2 : in2;
        // remainder takes the dividend's sign; everything else the XOR of both signs
        neg_acc  = (op[2] && op[1]) ? neg1 : (neg1 ^ neg2);
        div_zero = op[2] && (in2 == '0);
        div_ovf  = op[2] && !op[0] && (in1 == MIN_NEG) && (in2 == '1);
        special  = div_zero || div_ovf;
        if (div_zero) begin
            special_res = op[1] ? in1 : '1;
        end else begin
            special_res = op[1] ? '0 : in1;
        end
    end

    logic [XLEN:0]   add_sum, div_shift, div_diff;
    logic [XLEN-1:0] step_hi, step_lo;

    // One iteration: LSB-first shift-add for multiply, MSB-first restoring step for divide
    always_comb begin
        add_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_q} : '0);
        div_shift = {acc_hi, acc_lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        if (op_q[2]) begin
            step_hi = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
            step_lo = {acc_lo[XLEN-2:0], ~div_diff[XLEN]};
        end else begin
            step_hi = add_sum[XLEN:1];
            step_lo = {add_sum[0], acc_lo[XLEN-1:1]};
        end
    end

    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   div_val, div_fix, final_res;

    // Sign-correct the value produced by the last iteration and pick the requested half
    always_comb begin
        prod     = {step_hi, step_lo};
        prod_fix = neg_q ? -prod : prod;
        div_val  = op_q[1] ? step_hi : step_lo;
        div_fix  = neg_q ? -div_val : div_val;
        if (op_q[2]) begin
            final_res = div_fix;
        end else if (op_q[1:0] == 2'b00) begin
            final_res = prod_fix[XLEN-1:0];
        end else begin
            final_res = prod_fix[2*XLEN-1:XLEN];
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = special ? DONE : CALC;
            CALC:    if (cnt == CW'(1)) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs depend on state only
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Datapath: latch at accept, iterate in CALC, write result on the final iteration
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            op_q   <= '0;
            neg_q  <= 1'b0;
            opnd_q <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            out    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q   <= op;
                        neg_q  <= neg_acc;
                        acc_hi <= '0;
                        acc_lo <= op[2] ? mag1 : mag2;
                        opnd_q <= op[2] ? mag2 : mag1;
                        if (special) begin
                            cnt <= '0;
                            out <= special_res;
                        end else begin
                            cnt <= CW'(XLEN);
                        end
                    end
                end
                CALC: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    cnt    <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        out <= final_res;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit at XLEN=32 and XLEN=8.
// Results are pushed to a scoreboard at the accept edge and popped when out_valid is seen.
// Latency is counted in clock edges from the accept edge to the edge that raises out_valid.
module tb_muldiv_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, out_ready, sel8;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        rdy32, vld32, rdy8, vld8;
    logic [31:0] out32;
    logic [7:0]  out8;
    logic        rdy, vld;
    logic [31:0] res;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] sb_q[$];

    muldiv_unit #(.XLEN(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid & ~sel8), .in_ready(rdy32), .op(op),
        .in1(a), .in2(b), .out_valid(vld32), .out_ready(out_ready), .out(out32)
    );

    muldiv_unit #(.XLEN(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid & sel8), .in_ready(rdy8), .op(op),
        .in1(a[7:0]), .in2(b[7:0]), .out_valid(vld8), .out_ready(out_ready), .out(out8)
    );

    assign rdy = sel8 ? rdy8 : rdy32;
    assign vld = sel8 ? vld8 : vld32;
    assign res = sel8 ? {24'd0, out8} : out32;

    // Behavioural reference using native 64-bit arithmetic at width w
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input int w);
        logic [63:0] mask, ux, uy, up, rr;
        longint      sx, sy, r, minv;
        logic        ovf;
        mask = (64'd1 << w) - 64'd1;
        ux   = {32'd0, x} & mask;
        uy   = {32'd0, y} & mask;
        sx   = longint'(ux);
        sy   = longint'(uy);
        if (ux[w-1]) sx = sx - (longint'(1) <<< w);
        if (uy[w-1]) sy = sy - (longint'(1) <<< w);
        minv = -(longint'(1) <<< (w - 1));
        ovf  = (sx == minv) && (sy == -1);
        case (o)
            3'b000: r = sx * sy;
            3'b001: r = (sx * sy) >>> w;
            3'b010: r = (sx * longint'(uy)) >>> w;
            3'b011: begin up = (ux * uy) >> w; r = longint'(up); end
            3'b100: r = (uy == 0) ? longint'(mask) : (ovf ? sx : sx / sy);
            3'b101: r = (uy == 0) ? longint'(mask) : longint'(ux / uy);
            3'b110: r = (uy == 0) ? sx : (ovf ? longint'(0) : sx % sy);
            default: r = (uy == 0) ? longint'(ux) : longint'(ux % uy);
        endcase
        rr = r;
        return rr[31:0] & mask[31:0];
    endfunction

    function automatic bit is_special(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input int w);
        logic [63:0] mask, ux, uy;
        mask = (64'd1 << w) - 64'd1;
        ux   = {32'd0, x} & mask;
        uy   = {32'd0, y} & mask;
        return o[2] && ((uy == 0) || (!o[0] && ux == (64'd1 << (w - 1)) && uy == mask));
    endfunction

    // Issue one request, check latency, result, optional backpressure hold and handshake
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] expv, input int hold);
        int w, lat, n;
        bit spec;
        logic [31:0] got, exp_pop;
        w = sel8 ? 8 : 32;
        n = 0;
        while (!rdy && n < 100) begin @(negedge clk); n++; end
        vectors++;
        if (rdy !== 1'b1) begin
            $display("FAIL ready_wait: in_ready=%0b required 1", rdy);
            miscompares++;
        end
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk);
        sb_q.push_back(expv);
        spec = is_special(o, x, y, w);
        @(negedge clk);
        in_valid = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
        lat = 0;
        while (!vld && lat < 100) begin @(negedge clk); lat++; end
        vectors++;
        if (lat != (spec ? 0 : w)) begin
            $display("FAIL latency op=%0d w=%0d: got %0d edges required %0d", o, w, lat, spec ? 0 : w);
            miscompares++;
        end
        got = res;
        exp_pop = sb_q.pop_front();
        vectors++;
        if (got !== exp_pop) begin
            $display("FAIL result op=%0d w=%0d in1=%h in2=%h: got %h required %h", o, w, x, y, got, exp_pop);
            miscompares++;
        end
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1; op = 3'($urandom); a = $urandom; b = $urandom;
            @(negedge clk);
            vectors++;
            if (res !== got || rdy !== 1'b0 || vld !== 1'b1) begin
                $display("FAIL hold cycle %0d: out=%h in_ready=%0b out_valid=%0b required %h/0/1", k, res, rdy, vld, got);
                miscompares++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        vectors++;
        if (rdy !== 1'b1 || vld !== 1'b0) begin
            $display("FAIL handshake: in_ready=%0b out_valid=%0b required 1/0", rdy, vld);
            miscompares++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sel8 = 1'b0; op = '0; a = '0; b = '0;
        #1;
        vectors++;
        if (rdy32 !== 1'b1 || vld32 !== 1'b0 || out32 !== 32'd0) begin
            $display("FAIL reset32: in_ready=%0b out_valid=%0b out=%h required 1/0/0", rdy32, vld32, out32);
            miscompares++;
        end
        vectors++;
        if (rdy8 !== 1'b1 || vld8 !== 1'b0 || out8 !== 8'd0) begin
            $display("FAIL reset8: in_ready=%0b out_valid=%0b out=%h required 1/0/0", rdy8, vld8, out8);
            miscompares++;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mul();
        run_op(3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 0);
        run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0);
        run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 0);
        run_op(3'b010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 0);
        run_op(3'b000, 32'd0,        32'd12345,    32'd0,        0);
    endtask

    task automatic test_div();
        run_op(3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 0);
        run_op(3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 0);
        run_op(3'b101, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 0);
        run_op(3'b111, 32'hFFFFFFF9, 32'd2, 32'd1,        0);
    endtask

    task automatic test_special();
        run_op(3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 0);
        run_op(3'b111, 32'd5,        32'd0,        32'd5,        0);
        run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0);
        run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        0);
    endtask

    task automatic test_backpressure();
        run_op(3'b101, 32'd100, 32'd7, 32'd14, 10);
    endtask

    task automatic test_reset_mid_op();
        sel8 = 1'b0;
        op = 3'b100; a = 32'd1000; b = 32'd3; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        vectors++;
        if (vld32 !== 1'b0 || out32 !== 32'd0 || rdy32 !== 1'b1) begin
            $display("FAIL reset_mid_op: out_valid=%0b out=%h in_ready=%0b required 0/0/1", vld32, out32, rdy32);
            miscompares++;
        end
        @(negedge clk);
        rst = 1'b0;
        run_op(3'b000, 32'd3, 32'd4, 32'd12, 0);
    endtask

    task automatic test_xlen8();
        sel8 = 1'b1;
        run_op(3'b100, 32'h80, 32'hFF, 32'h80, 0);
        run_op(3'b011, 32'hFF, 32'hFF, 32'hFE, 0);
        run_op(3'b110, 32'hF9, 32'h02, 32'hFF, 0);
        sel8 = 1'b0;
    endtask

    task automatic test_random();
        logic [2:0]  o;
        logic [31:0] x, y;
        for (int i = 0; i < 1000; i++) begin
            sel8 = (i >= 500);
            o = 3'($urandom);
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: y = 32'd0;
                1: begin x = sel8 ? 32'h80 : 32'h80000000; y = 32'hFFFFFFFF; end
                2: y = $urandom_range(0, 3);
                3: x = 32'd0;
                default: ;
            endcase
            run_op(o, x, y, model(o, x, y, sel8 ? 8 : 32), 0);
        end
        sel8 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_backpressure();
        test_reset_mid_op();
        test_xlen8();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
